// File: rtl/mod_n_counter_pkg.sv
// Shared constants and helpers for the modulo-N counter family (board LED
// counter and 7-seg digit chains).
package mod_n_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int LED_MODULUS   = 12;
  localparam int LED_PRESCALE  = 1;
  localparam int DIGIT_MODULUS = 10;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_STEP = 2'd1,
    OP_LOAD = 2'd2,
    OP_CLR  = 2'd3
  } cnt_op_e;

  // Per-edge action, clear beats load beats step.
  function automatic cnt_op_e sel_op(input logic clr, input logic load, input logic step);
    if (clr)  return OP_CLR;
    if (load) return OP_LOAD;
    if (step) return OP_STEP;
    return OP_HOLD;
  endfunction

endpackage

// File: rtl/clk_prescaler.sv
// Enable-gated prescaler: emits a one-cycle step every PRESCALE enabled cycles.
// Also used by display refresh logic.
module clk_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic sync_clr,
  output logic step
);

  localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  if (PRESCALE < 1) begin : g_bad_prescale
    $error("clk_prescaler: PRESCALE must be >= 1");
  end

  logic [PW-1:0] pre;

  // With PRESCALE=1 the phase register stays at zero, so step follows en.
  assign step = en && (pre == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               pre <= '0;
    else if (sync_clr || step) pre <= '0;
    else if (en)              pre <= pre + PW'(1);
  end

endmodule

// File: rtl/mod_n_counter.sv
// Parametrised modulo-N up/down counter with clear, clamped load, prescaled
// enable and cascade carry/borrow for digit chains.
module mod_n_counter
  import mod_n_counter_pkg::*;
#(
  parameter int MODULUS  = LED_MODULUS,
  parameter int WIDTH    = 4,
  parameter int PRESCALE = LED_PRESCALE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             co
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 1);

  if (MODULUS < 2 || (WIDTH < 31 && MODULUS > (1 << WIDTH))) begin : g_bad_params
    $error("mod_n_counter: need 2 <= MODULUS <= 2**WIDTH");
  end

  logic    step;
  cnt_op_e op;

  clk_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .sync_clr (clr | load),
    .step     (step)
  );

  assign op = sel_op(clr, load, step);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      unique case (op)
        OP_CLR:  count <= '0;
        OP_LOAD: count <= (load_val > TOP) ? TOP : load_val;
        OP_STEP: begin
          if (up == DIR_DOWN) count <= (count == '0)  ? TOP : count - WIDTH'(1);
          else                count <= (count == TOP) ? '0  : count + WIDTH'(1);
        end
        default: count <= count;
      endcase
    end
  end

  assign tc = (up == DIR_UP) ? (count == TOP) : (count == '0);
  // Gate with reset so a down-counting enabled chain never carries while held in reset.
  assign co = reset && tc && (op == OP_STEP);

endmodule

// File: tb/tb_mod_n_counter.sv
// Randomized and directed bench for mod_n_counter: an arithmetic reference model
// tracks a PRESCALE=1 and a PRESCALE=4 instance; a two-digit cascade is checked as 0..99.
module tb_mod_n_counter;
  import mod_n_counter_pkg::*;

  localparam int M = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
  logic [3:0] load_val = '0;
  logic [3:0] cnt_a, cnt_b;
  logic       tc_a, co_a, tc_b, co_b;
  logic       casc_en = 1'b0;
  logic [3:0] units, tens;
  logic       tc_u, co_u, tc_t, co_t;

  int checks = 0, errors = 0;
  int mc[2];
  int mp[2];
  int k;

  always #10 clk = ~clk;

  mod_n_counter #(.MODULUS(M), .WIDTH(4), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_a), .tc(tc_a), .co(co_a));

  mod_n_counter #(.MODULUS(M), .WIDTH(4), .PRESCALE(4)) dut_b (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(load_val), .count(cnt_b), .tc(tc_b), .co(co_b));

  mod_n_counter #(.MODULUS(DIGIT_MODULUS), .WIDTH(4), .PRESCALE(1)) dut_units (
    .clk(clk), .reset(reset), .en(casc_en), .up(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .count(units), .tc(tc_u), .co(co_u));

  mod_n_counter #(.MODULUS(DIGIT_MODULUS), .WIDTH(4), .PRESCALE(1)) dut_tens (
    .clk(clk), .reset(reset), .en(co_u), .up(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .count(tens), .tc(tc_t), .co(co_t));

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ps(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // One clock: drive on the falling edge, check settled outputs, then advance the model.
  task automatic cycle(input logic e, input logic u, input logic c, input logic l,
                       input logic [3:0] v);
    int  tce[2];
    bit  stp[2];
    @(negedge clk);
    en = e; up = u; clr = c; load = l; load_val = v;
    #1;
    for (int i = 0; i < 2; i++) begin
      tce[i] = u ? int'(mc[i] == M - 1) : int'(mc[i] == 0);
      stp[i] = e && !c && !l && (mp[i] == ps(i) - 1);
    end
    chk("count_a", cnt_a, mc[0]);
    chk("tc_a", tc_a, tce[0]);
    chk("co_a", co_a, tce[0] & int'(stp[0]));
    chk("count_b", cnt_b, mc[1]);
    chk("tc_b", tc_b, tce[1]);
    chk("co_b", co_b, tce[1] & int'(stp[1]));
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (c) begin
        mc[i] = 0; mp[i] = 0;
      end else if (l) begin
        mc[i] = (int'(v) >= M) ? M - 1 : int'(v);
        mp[i] = 0;
      end else if (e) begin
        if (stp[i]) mc[i] = u ? (mc[i] + 1) % M : (mc[i] + M - 1) % M;
        mp[i] = (mp[i] + 1) % ps(i);
      end
    end
  endtask

  // Assert reset between edges; count must clear before any clock edge.
  task automatic async_reset(input logic u);
    @(negedge clk);
    en = 1'b1; up = u; clr = 1'b0; load = 1'b0;
    #4 reset = 1'b0;
    #1;
    chk("rst_count_a", cnt_a, 0);
    chk("rst_count_b", cnt_b, 0);
    chk("rst_tc_a", tc_a, u ? 0 : 1);
    chk("rst_co_a", co_a, 0);
    chk("rst_co_b", co_b, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_hold_a", cnt_a, 0);
    chk("rst_hold_units", units, 0);
    en = 1'b0;
    reset = 1'b1;
    mc = '{0, 0};
    mp = '{0, 0};
    k = 0;
  endtask

  initial begin
    mc = '{0, 0};
    mp = '{0, 0};
    k = 0;
    en = 1'b1;
    #25;
    chk("init_count_a", cnt_a, 0);
    chk("init_tc_a", tc_a, 0);
    chk("init_co_a", co_a, 0);
    @(negedge clk);
    en = 1'b0;
    reset = 1'b1;

    // Up through a wrap, then down from zero through a wrap.
    for (int i = 0; i < 26; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 26; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

    // Load, clamped load, clear+load, load while sitting at terminal count.
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'd14);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'd7);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'd11);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 4'd3);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);

    // Enable gap in the middle of a prescale period.
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

    // Reset mid-count at 7, then restart from 0.
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    async_reset(1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

    for (int i = 0; i < 300; i++)
      cycle(logic'(($urandom % 4) != 0), logic'($urandom % 2),
            logic'(($urandom % 16) == 0), logic'(($urandom % 12) == 0),
            4'($urandom % 16));

    // Cascaded digits must read as a 0..99 decimal counter.
    async_reset(1'b0);
    casc_en = 1'b1;
    for (int i = 0; i < 130; i++) begin
      #1;
      chk("cascade_value", int'(tens) * 10 + int'(units), k % 100);
      chk("cascade_carry", co_u, int'((k % 10) == 9));
      @(posedge clk);
      k++;
      @(negedge clk);
    end
    casc_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
